// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with 2-flop line synchroniser, optional parity, 1-2 stop bits.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling per bit.
module uart_rx_param #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BPS         = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int BIT_CNT = CLK_FREQ / BPS;
  localparam int CW      = $clog2(BIT_CNT + 1);
  localparam int BW      = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST     = CW'(BIT_CNT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          LAST_STP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [1:0]             sync;
  logic                   line, line_d;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr, ferr;
  logic                   samp, bit_val;

  assign line = sync[1];

`ifdef UART_RX_MAJORITY_EN
  // Decision taken on the third sample; the two earlier ones are captured here.
  localparam logic [CW-1:0] SAMP   = CW'(BIT_CNT / 2 + 1);
  localparam logic [CW-1:0] SAMP_A = CW'(BIT_CNT / 2 - 1);
  localparam logic [CW-1:0] SAMP_B = CW'(BIT_CNT / 2);
  logic s_a, s_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else begin
      if (cnt == SAMP_A) s_a <= line;
      if (cnt == SAMP_B) s_b <= line;
    end
  end
  assign bit_val = (s_a & s_b) | (s_a & line) | (s_b & line);
`else
  localparam logic [CW-1:0] SAMP = CW'(BIT_CNT / 2);
  assign bit_val = line;
`endif

  assign samp = (state != IDLE) && (cnt == SAMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sync          <= 2'b11;
      line_d        <= 1'b1;
      cnt           <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      shreg         <= '0;
      perr          <= 1'b0;
      ferr          <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      sync       <= {sync[0], uart_rxd};
      line_d     <= line;
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (state != IDLE) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (line_d && !line) begin
          state    <= START;
          cnt      <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
        end
        START: begin
          if (samp && bit_val) state <= IDLE;
          else if (cnt == LAST) state <= DATA;
        end
        DATA: begin
          if (samp) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (cnt == LAST) begin
            if (bit_idx == LAST_BIT) state <= (PARITY_MODE != 0) ? PARITY : STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        PARITY: begin
          if (samp)
            perr <= (PARITY_MODE == 1) ? ~(^shreg ^ bit_val) : (^shreg ^ bit_val);
          if (cnt == LAST) state <= STOP;
        end
        STOP: begin
          // Final stop sample returns to IDLE at once so back-to-back starts are caught.
          if (samp && stop_idx == LAST_STP) begin
            state         <= IDLE;
            rx_data       <= shreg;
            rx_parity_err <= perr;
            rx_frame_err  <= ferr | ~bit_val;
            rx_valid      <= 1'b1;
            rx_overrun    <= rx_valid & ~rx_ready;
          end else begin
            if (samp) ferr <= ferr | ~bit_val;
            if (cnt == LAST) stop_idx <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BPS, default 115_200, line baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal values are 5..9.
REQ-004 SHALL have parameter PARITY_MODE, default 0, where 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values are 1..2.
REQ-006 SHALL have port clk, input, 1 bit, system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port uart_rxd, input, 1 bit, asynchronous serial line that idles high.
REQ-009 SHALL have port rx_data, output, DATA_BITS wide, received word, LSB first on the line.
REQ-010 SHALL have port rx_valid, output, 1 bit, rx_data and error flags are valid.
REQ-011 SHALL have port rx_ready, input, 1 bit, consumer accepts the word.
REQ-012 SHALL have port rx_parity_err, output, 1 bit, parity mismatch for the held word; tied 0 when PARITY_MODE = 0.
REQ-013 SHALL have port rx_frame_err, output, 1 bit, at least one stop bit sampled low for the held word.
REQ-014 SHALL have port rx_overrun, output, 1 bit, one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-015 SHALL synchronise uart_rxd through 2 flops; all line references below mean the synchronised signal (2-cycle latency).
REQ-016 SHALL use BIT_CNT = CLK_FREQ/BPS (integer division) clocks per bit and sample each bit at count BIT_CNT/2.
REQ-017 SHALL implement the states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL move IDLE -> START on a high-to-low transition of the line.
REQ-019 SHALL, in START, go to DATA if the mid-bit sample is 0, and go back to IDLE with no output if it is 1 (false start).
REQ-020 SHALL, in DATA, shift in DATA_BITS samples, the first received into bit 0, then go to PARITY if PARITY_MODE != 0, else to STOP.
REQ-021 SHALL, in PARITY, compare one sample against XOR of the data bits: odd mode expects XOR of data and parity = 1, even mode expects 0.
REQ-022 SHALL, in STOP, sample STOP_BITS stop bits and set the frame error if any sample is 0.
REQ-023 SHALL enter IDLE directly after the final stop-bit mid-sample, so a start edge arriving half a bit later is captured (back-to-back frames).
REQ-024 SHALL update rx_data, rx_parity_err and rx_frame_err and assert rx_valid on the cycle after the final stop sample.
REQ-025 SHALL hold rx_valid until the first cycle with rx_valid = 1 and rx_ready = 1, and clear it on the next edge.
REQ-026 SHALL, when a new word completes while rx_valid = 1 and rx_ready = 0, overwrite the held word, keep rx_valid = 1 and pulse rx_overrun for 1 cycle.
REQ-027 SHALL, when a new word completes on the same cycle as a handshake, load the new word, keep rx_valid = 1 and not pulse rx_overrun.
REQ-028 SHALL deliver words that carry parity or frame errors normally; errors never suppress rx_valid.

Reset
REQ-029 SHALL, while rst_n = 0, force the FSM to IDLE, clear all counters, load the synchroniser with 1, and drive rx_data = 0, rx_valid = 0, all error flags = 0 and rx_overrun = 0.
REQ-030 SHALL, on reset mid-frame, discard the partial frame; after release, the next start edge is the first one that counts.

Configuration
REQ-031 SHALL, with UART_RX_MAJORITY_EN defined, sample at counts BIT_CNT/2-1, BIT_CNT/2 and BIT_CNT/2+1 and use the 2-of-3 majority for every bit, including the start-bit check.
REQ-032 SHALL, with UART_RX_MAJORITY_EN undefined, take a single sample at BIT_CNT/2, and the interface SHALL be identical in both builds.

Verification
REQ-033 SHALL pass: defaults with BIT_CNT = 434, rx_ready = 1, frame 0x41 then 0x0F with a 7-bit idle gap -> two rx_valid pulses with rx_data = 0x41 then 0x0F, and no error flags.
REQ-034 SHALL pass: low glitch of 100 clocks on an idle line -> return to IDLE, no rx_valid.
REQ-035 SHALL pass: PARITY_MODE = 2 with 0x41 and parity bit 1 -> rx_data = 0x41, rx_parity_err = 1; with parity bit 0 -> rx_parity_err = 0.
REQ-036 SHALL pass: STOP_BITS = 2 with the second stop bit low -> rx_frame_err = 1, rx_data still correct.
REQ-037 SHALL pass: rx_ready = 0 over frames 0x55 then 0xAA -> rx_overrun pulses once, rx_data = 0xAA, rx_valid stays 1 until rx_ready is raised.
REQ-038 SHALL pass: rst_n low for 3 clocks during data bit 4 -> all outputs 0; the next full frame 0x3C is received correctly.
